// File: rtl/instr_rom_loader_if.sv
// Fetch and program-download signal bundle for instr_rom_loader.
// The memory takes the slave side; the core/loader takes the master side.
interface instr_rom_loader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 256
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ready;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_fault;
    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic [CNT_W-1:0]      load_count;
    logic                  busy;

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
        output fetch_ready, fetch_valid, fetch_data, fetch_fault, load_ready, load_count, busy
    );

    modport master (
        output fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
        input  fetch_ready, fetch_valid, fetch_data, fetch_fault, load_ready, load_count, busy
    );
endinterface

// File: rtl/instr_rom_loader.sv
// Instruction memory with one-cycle byte-addressed fetch, streaming program
// download and a post-reset clear to FILL_WORD. Faulting fetches (misaligned
// or beyond DEPTH) return FAULT_WORD with fetch_fault set.
module instr_rom_loader #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 256,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0,
    parameter logic [DATA_WIDTH-1:0] FAULT_WORD = DATA_WIDTH'(32'h00000013)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_rom_loader_if.slave    bus
);
    localparam int unsigned OFF   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W = ADDR_WIDTH - OFF;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF) - 1);

    typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  fvalid_q;
    logic [DATA_WIDTH-1:0] fdata_q;
    logic                  ffault_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  fetch_ready;
    logic                  load_ready;
    logic                  fetch_acc;
    logic [IDX_W-1:0]      idx;
    logic                  fault;
    logic [DATA_WIDTH-1:0] rd_word;

    // Fetch address decode: word index, alignment and range check.
    always_comb begin
        idx       = bus.fetch_addr[ADDR_WIDTH-1:OFF];
        fault     = (|(bus.fetch_addr & OFF_MASK)) || (32'(idx) >= DEPTH);
        rd_word   = mem_q[idx[PTR_W-1:0]];
        fetch_acc = bus.fetch_req && fetch_ready;
    end

    // Next-state logic: clear sweep, run, and streaming load with auto-stop at the last word.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        wr_en       = 1'b0;
        wr_data     = FILL_WORD;
        fetch_ready = 1'b0;
        load_ready  = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                wr_en = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = S_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            S_RUN: begin
                fetch_ready = 1'b1;
                if (bus.load_start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (bus.load_valid) begin
                    wr_en   = 1'b1;
                    wr_data = bus.load_data;
                    ptr_d   = ptr_q + PTR_W'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (bus.load_last || ptr_q == LAST_PTR) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Control and fetch-response registers; reset aborts any clear or load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_CLEAR;
            ptr_q    <= '0;
            cnt_q    <= '0;
            fvalid_q <= 1'b0;
            fdata_q  <= '0;
            ffault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            fvalid_q <= fetch_acc;
            if (fetch_acc) begin
                fdata_q  <= fault ? FAULT_WORD : rd_word;
                ffault_q <= fault;
            end
        end
    end

    // Word storage; written by the clear sweep or by accepted load words.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_q] <= wr_data;
        end
    end

    assign bus.fetch_ready = fetch_ready;
    assign bus.fetch_valid = fvalid_q;
    assign bus.fetch_data  = fdata_q;
    assign bus.fetch_fault = ffault_q;
    assign bus.load_ready  = load_ready;
    assign bus.load_count  = cnt_q;
    assign bus.busy        = (state_q != S_RUN);
endmodule

// File: tb/tb_instr_rom_loader.sv
// Self-checking bench for instr_rom_loader (DEPTH=8, 32-bit words, 6-bit PC).
// A word-array model predicts every fetch response; a per-cycle compare
// process checks it plus the handshake/status outputs, and directed tests
// pin key values with literal expectations.
module tb_instr_rom_loader;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 6;
    localparam logic [31:0] FILL  = 32'h00000000;
    localparam logic [31:0] FAULT = 32'h00000013;

    typedef struct packed {
        logic [31:0] d;
        logic        f;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_rom_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus_if ();

    instr_rom_loader #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .ADDR_WIDTH(AW),
        .FILL_WORD(FILL),
        .FAULT_WORD(FAULT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_if)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model state
    logic [31:0] mdl_mem [DEPTH];
    bit          m_run   = 1'b0;
    bit          m_load  = 1'b0;
    int unsigned m_count = 0;
    int unsigned wp      = 0;
    resp_t       exp_q [$];
    resp_t       last_r  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic resp_t model_fetch(input logic [AW-1:0] a);
        resp_t r;
        int unsigned ai;
        ai = int'(a);
        if ((ai % 4) != 0 || (ai / 4) >= DEPTH) begin
            r.d = FAULT;
            r.f = 1'b1;
        end else begin
            r.d = mdl_mem[ai / 4];
            r.f = 1'b0;
        end
        return r;
    endfunction

    // Record the response owed for each fetch the memory should accept.
    always @(posedge clk) begin
        if (rst_n && bus_if.fetch_req && m_run) exp_q.push_back(model_fetch(bus_if.fetch_addr));
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        resp_t e;
        check("busy", 64'(bus_if.busy), 64'(!m_run));
        check("fetch_ready", 64'(bus_if.fetch_ready), 64'(m_run));
        check("load_ready", 64'(bus_if.load_ready), 64'(m_load));
        check("load_count", 64'(bus_if.load_count), 64'(m_count));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fetch_valid", 64'(bus_if.fetch_valid), 64'd1);
            check("fetch_data", 64'(bus_if.fetch_data), 64'(e.d));
            check("fetch_fault", 64'(bus_if.fetch_fault), 64'(e.f));
            last_r = e;
        end else begin
            check("fetch_valid_idle", 64'(bus_if.fetch_valid), 64'd0);
            check("fetch_data_hold", 64'(bus_if.fetch_data), 64'(last_r.d));
            check("fetch_fault_hold", 64'(bus_if.fetch_fault), 64'(last_r.f));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fetch_ready"}, 64'(bus_if.fetch_ready), 64'd0);
        check({tag, "_fetch_valid"}, 64'(bus_if.fetch_valid), 64'd0);
        check({tag, "_fetch_data"}, 64'(bus_if.fetch_data), 64'd0);
        check({tag, "_fetch_fault"}, 64'(bus_if.fetch_fault), 64'd0);
        check({tag, "_load_ready"}, 64'(bus_if.load_ready), 64'd0);
        check({tag, "_load_count"}, 64'(bus_if.load_count), 64'd0);
        check({tag, "_busy"}, 64'(bus_if.busy), 64'd1);
    endtask

    // Release reset on a falling edge, then wait out the DEPTH-cycle clear.
    task automatic release_and_clear();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DEPTH) @(posedge clk);
        #1;
        m_run = 1'b1;
    endtask

    // Single fetch with a literal expectation on the response cycle.
    task automatic fetch_one(input logic [AW-1:0] a, input logic [31:0] exp_d, input logic exp_f);
        bus_if.fetch_req  = 1'b1;
        bus_if.fetch_addr = a;
        tick();
        bus_if.fetch_req  = 1'b0;
        @(negedge clk);
        check("lit_valid", 64'(bus_if.fetch_valid), 64'd1);
        check("lit_data", 64'(bus_if.fetch_data), 64'(exp_d));
        check("lit_fault", 64'(bus_if.fetch_fault), 64'(exp_f));
        tick();
    endtask

    task automatic enter_load();
        bus_if.load_start = 1'b1;
        tick();
        bus_if.load_start = 1'b0;
        m_run   = 1'b0;
        m_load  = 1'b1;
        m_count = 0;
        wp      = 0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        bus_if.load_valid = 1'b1;
        bus_if.load_data  = d;
        bus_if.load_last  = last;
        tick();
        if (m_load) begin
            mdl_mem[wp] = d;
            wp++;
            m_count++;
            if (last || wp == DEPTH) begin
                m_load = 1'b0;
                m_run  = 1'b1;
            end
        end
        bus_if.load_valid = 1'b0;
        bus_if.load_last  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        bus_if.fetch_req  = 1'b0;
        bus_if.fetch_addr = '0;
        bus_if.load_start = 1'b0;
        bus_if.load_valid = 1'b0;
        bus_if.load_data  = '0;
        bus_if.load_last  = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = FILL;

        // Reset state and post-reset clear
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        release_and_clear();

        // Back-to-back fetch of every word after clear
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus_if.fetch_req  = 1'b1;
            bus_if.fetch_addr = AW'(4 * i);
            tick();
        end
        bus_if.fetch_req = 1'b0;
        tick();

        // Short download terminated by load_last
        enter_load();
        load_word(32'h00052503, 1'b0);
        load_word(32'h0045a583, 1'b0);
        load_word(32'h00a58633, 1'b1);
        tick();
        check("count_after_last", 64'(bus_if.load_count), 64'd3);
        fetch_one(6'h04, 32'h0045a583, 1'b0);
        fetch_one(6'h0C, 32'h00000000, 1'b0);
        fetch_one(6'h08, 32'h00a58633, 1'b0);

        // Fault cases and last in-range word
        fetch_one(6'h06, FAULT, 1'b1);
        fetch_one(6'h20, FAULT, 1'b1);
        fetch_one(6'h3C, FAULT, 1'b1);
        fetch_one(6'h1C, 32'h00000000, 1'b0);

        // Overlong download without load_last stops after the last word
        enter_load();
        for (int i = 0; i < 10; i++) load_word(32'h000000A0 + 32'(i), 1'b0);
        tick();
        check("count_after_full", 64'(bus_if.load_count), 64'd8);
        fetch_one(6'h1C, 32'h000000A7, 1'b0);
        fetch_one(6'h00, 32'h000000A0, 1'b0);

        // load_start and fetch in the same RUN cycle
        bus_if.load_start = 1'b1;
        bus_if.fetch_req  = 1'b1;
        bus_if.fetch_addr = 6'h08;
        tick();
        bus_if.load_start = 1'b0;
        bus_if.fetch_req  = 1'b0;
        m_run   = 1'b0;
        m_load  = 1'b1;
        m_count = 0;
        wp      = 0;
        @(negedge clk);
        check("overlap_valid", 64'(bus_if.fetch_valid), 64'd1);
        check("overlap_data", 64'(bus_if.fetch_data), 64'h000000A2);
        check("load_ready_in_load", 64'(bus_if.load_ready), 64'd1);
        tick();

        // Fetch requested during LOAD is not accepted
        bus_if.fetch_req  = 1'b1;
        bus_if.fetch_addr = 6'h00;
        tick();
        bus_if.fetch_req  = 1'b0;
        @(negedge clk);
        check("load_fetch_blocked", 64'(bus_if.fetch_valid), 64'd0);
        check("load_fetch_hold", 64'(bus_if.fetch_data), 64'h000000A2);
        tick();

        // Two words (load_start during LOAD is ignored), then reset mid-download
        bus_if.load_start = 1'b1;
        load_word(32'h00000011, 1'b0);
        bus_if.load_start = 1'b0;
        load_word(32'h00000022, 1'b0);
        check("count_before_abort", 64'(bus_if.load_count), 64'd2);
        bus_if.load_valid = 1'b1;
        bus_if.load_data  = 32'h00000033;
        #2;
        rst_n   = 1'b0;
        m_run   = 1'b0;
        m_load  = 1'b0;
        m_count = 0;
        last_r  = '0;
        for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = FILL;
        #1;
        check_reset_outputs("rst_async");
        bus_if.load_valid = 1'b0;
        repeat (2) @(negedge clk);
        release_and_clear();
        fetch_one(6'h00, FILL, 1'b0);
        fetch_one(6'h04, FILL, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_rom_loader.md
Name: instr_rom_loader

Overview:
- Parametrised instruction memory that succeeds the fixed combinational program table.
- Provides a word-deep RAM image with a synchronous, byte-addressed fetch port for the core's PC.
- Supports in-system program download through a streaming load port.
- Clears itself to a fill word after reset and flags misaligned or out-of-range fetches.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits; must be 8 x a power of two.
- DEPTH, 256, number of words; need not be a power of two.
- ADDR_WIDTH, 10, fetch byte-address width; must satisfy 2**ADDR_WIDTH >= DEPTH*DATA_WIDTH/8.
- FILL_WORD, 32'h00000000, value written to every word during post-reset clear.
- FAULT_WORD, 32'h00000013, value returned on a faulting fetch (RISC-V NOP).

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- fetch_req, input, 1, fetch request.
- fetch_addr, input, ADDR_WIDTH, byte address (PC).
- fetch_ready, output, 1, fetch request accepted this cycle when high with fetch_req.
- fetch_valid, output, 1, fetch_data/fetch_fault valid (one-cycle pulse per accepted request).
- fetch_data, output, DATA_WIDTH, fetched instruction.
- fetch_fault, output, 1, accepted address was misaligned or out of range.
- load_start, input, 1, begin program download at word 0.
- load_valid, input, 1, load_data present.
- load_data, input, DATA_WIDTH, program word.
- load_last, input, 1, final word of download (qualified by load_valid).
- load_ready, output, 1, load word accepted when high with load_valid.
- load_count, output, clog2(DEPTH+1), words written in current/last download.
- busy, output, 1, high in CLEAR or LOAD.

Behaviour:
- Reset values: state CLEAR, clear pointer 0, fetch_ready=0, fetch_valid=0, fetch_data=0, fetch_fault=0, load_ready=0, load_count=0, busy=1. Reset asserted mid-operation aborts any load or clear immediately; memory contents are then rewritten by CLEAR.
- States: CLEAR, RUN, LOAD.
- CLEAR: writes FILL_WORD to word[ptr] each cycle, ptr 0..DEPTH-1 (exactly DEPTH cycles). After writing DEPTH-1 it goes to RUN. fetch_ready=0, load_ready=0; load_start is ignored.
- RUN: fetch_ready=1, load_ready=0.
  - load_start moves to LOAD next cycle, with write pointer=0 and load_count=0.
  - A fetch accepted in the same cycle as load_start still completes normally.
- LOAD: fetch_ready=0, load_ready=1.
  - Each load_valid writes load_data to word[ptr], then ptr++ and load_count++.
  - load_valid&&load_last goes to RUN next cycle.
  - A write to word DEPTH-1 also goes to RUN, whether or not load_last is set. Further load words are dropped (load_ready=0).
  - load_start is ignored while in LOAD.
  - load_count holds its value after returning to RUN until the next load_start.
- Fetch decode:
  - OFF = log2(DATA_WIDTH/8) low bits are the byte offset.
  - Word index = fetch_addr[ADDR_WIDTH-1:OFF].
  - Misaligned if offset != 0; out of range if index >= DEPTH.
- Fetch latency is one cycle. Request accepted at edge N gives fetch_valid=1 during cycle N+1 with:
  - fetch_data = word[index] and fetch_fault=0, or
  - fetch_data = FAULT_WORD and fetch_fault=1.
- fetch_valid is low otherwise. fetch_data and fetch_fault hold their last values while fetch_valid=0.
- No output backpressure; back-to-back requests give fetch_valid every cycle.
- Read-during-write cannot occur: fetch and load are never both enabled in the same cycle.
- The first fetch is accepted DEPTH cycles after rst_n deasserts.

Test Plan:
- Reset release, DEPTH=8 -> busy=1 and fetch_ready=0 for 8 cycles. Then fetch at 0x00,0x04,...,0x1C returns FILL_WORD with fetch_valid one cycle after each accept, back-to-back.
- Load 0x00052503, 0x0045a583, 0x00a58633 with last on the third word -> load_count=3 and state returns to RUN. Fetch 0x04 returns 0x0045a583; fetch 0x0C returns FILL_WORD.
- Fetch 0x06 -> fetch_fault=1 and fetch_data=0x00000013. Fetch 0x20 with DEPTH=8 -> fetch_fault=1 out of range. Fetch 0x1C -> fault=0.
- Load 10 words without load_last, DEPTH=8 -> auto-return to RUN after the 8th write, load_count=8, words 9-10 not accepted. Word 7 holds the 8th value.
- load_start with fetch_req in the same RUN cycle at 0x08 -> fetch_valid next cycle with the old contents. fetch_ready=0 throughout LOAD.
- Assert rst_n low after 2 of 4 load words -> all outputs take reset values asynchronously. After CLEAR completes, fetch 0x00 returns FILL_WORD.
